// File: rtl/avmm_mem_pkg.sv
// Shared definitions for the Avalon-MM burst memory slave: FSM encodings,
// error flag positions and the word-index width helper.
package avmm_mem_pkg;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_ISSUE = 1'b1
    } rd_state_e;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } wr_state_e;

    localparam int ERR_RD_BC = 0;
    localparam int ERR_WR_BC = 1;
    localparam int ERR_ALIGN = 2;
    localparam int ERR_W     = 3;
    localparam int BC_W      = 9;

    // A depth of one word still needs a one-bit index to keep port widths legal.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/avmm_sram_dp_core.sv
// Simple dual-port RAM: one write port, one registered read port, followed by
// a READ_LATENCY-1 stage delay line carrying valid and data.
module avmm_sram_dp_core
    import avmm_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 2,
    parameter int IDX_W        = idx_width(MEM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
);

    logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Stage 0 samples the array before this edge's write lands (read-first);
    // every data stage only loads on a valid beat so the output holds otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= re_i;
            if (re_i) begin
                dat_q[0] <= mem_q[raddr_i];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rdata_o  = dat_q[READ_LATENCY-1];
    assign rvalid_o = vld_q[READ_LATENCY-1];

endmodule

// File: rtl/avmm_burst_mem_slave.sv
// Avalon-MM burst memory slave: independent read and write burst FSMs over a
// dual-port RAM, with optional periodic write stalls and sticky error flags.
module avmm_burst_mem_slave
    import avmm_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MEM_WORDS       = 4096,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_BURST       = 256,
    parameter int WR_STALL_PERIOD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs_address,
    input  logic                  rs_read,
    input  logic [8:0]            rs_burstcount,
    output logic                  rs_waitrequest,
    output logic [DATA_WIDTH-1:0] rs_readdata,
    output logic                  rs_readdatavalid,
    input  logic [ADDR_WIDTH-1:0] ws_address,
    input  logic                  ws_write,
    input  logic [DATA_WIDTH-1:0] ws_writedata,
    input  logic [8:0]            ws_burstcount,
    output logic                  ws_waitrequest,
    input  logic                  err_clear,
    output logic [2:0]            err_status
);

    localparam int              IDX_W      = idx_width(MEM_WORDS);
    localparam logic [BC_W-1:0] MAX_BC     = BC_W'(MAX_BURST);
    localparam logic [BC_W-1:0] BC_ONE     = BC_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [31:0]     STALL_LAST = (WR_STALL_PERIOD > 0) ? 32'(WR_STALL_PERIOD - 1) : 32'd0;

    rd_state_e        rd_state_q, rd_state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [BC_W-1:0]  rd_cnt_q, rd_cnt_d;
    wr_state_e        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [BC_W-1:0]  wr_rem_q, wr_rem_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic [ERR_W-1:0] err_q, err_d, err_set;

    logic             ram_we, ram_re;
    logic [IDX_W-1:0] ram_waddr, ram_raddr;
    logic [IDX_W-1:0] rs_idx, ws_idx;
    logic             rs_bc_ok, ws_bc_ok, stall, wr_acc;
    logic             unused_addr;

    // Byte address to word index; bits above the RAM depth are ignored (wrap).
    assign rs_idx      = rs_address[IDX_W+1:2];
    assign ws_idx      = ws_address[IDX_W+1:2];
    assign unused_addr = ^{rs_address, ws_address};

    assign rs_bc_ok = (rs_burstcount != '0) && (rs_burstcount <= MAX_BC);
    assign ws_bc_ok = (ws_burstcount != '0) && (ws_burstcount <= MAX_BC);

    assign stall          = (WR_STALL_PERIOD != 0) && (stall_cnt_q == STALL_LAST);
    assign rs_waitrequest = (rd_state_q == R_ISSUE);
    assign ws_waitrequest = (wr_state_q == W_BURST) && stall;
    assign wr_acc         = ws_write && !ws_waitrequest;
    assign err_status     = err_q;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_cnt_d   = rd_cnt_q;
        ram_re     = 1'b0;
        ram_raddr  = rd_idx_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rs_read && rs_bc_ok) begin
                    rd_idx_d   = rs_idx;
                    rd_cnt_d   = rs_burstcount;
                    rd_state_d = R_ISSUE;
                end
            end
            R_ISSUE: begin
                ram_re   = 1'b1;
                rd_idx_d = rd_idx_q + IDX_ONE;
                rd_cnt_d = rd_cnt_q - BC_ONE;
                if (rd_cnt_q == BC_ONE) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_rem_d   = wr_rem_q;
        ram_we     = 1'b0;
        ram_waddr  = wr_idx_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_acc && ws_bc_ok) begin
                    ram_we    = 1'b1;
                    ram_waddr = ws_idx;
                    if (ws_burstcount != BC_ONE) begin
                        wr_state_d = W_BURST;
                        wr_rem_d   = ws_burstcount - BC_ONE;
                        wr_idx_d   = ws_idx + IDX_ONE;
                    end
                end
            end
            W_BURST: begin
                if (wr_acc) begin
                    ram_we   = 1'b1;
                    wr_idx_d = wr_idx_q + IDX_ONE;
                    wr_rem_d = wr_rem_q - BC_ONE;
                    if (wr_rem_q == BC_ONE) begin
                        wr_state_d = W_IDLE;
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Errors are only raised when a command or first beat is actually taken;
    // a fresh error overrides a simultaneous clear.
    always_comb begin
        err_set = '0;
        if (rd_state_q == R_IDLE && rs_read) begin
            err_set[ERR_RD_BC] = !rs_bc_ok;
            err_set[ERR_ALIGN] = |rs_address[1:0];
        end
        if (wr_state_q == W_IDLE && wr_acc) begin
            err_set[ERR_WR_BC] = !ws_bc_ok;
            if (|ws_address[1:0]) begin
                err_set[ERR_ALIGN] = 1'b1;
            end
        end
        err_d = (err_clear ? '0 : err_q) | err_set;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'd1;
        if (WR_STALL_PERIOD == 0 || stall_cnt_q == STALL_LAST) begin
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q  <= R_IDLE;
            rd_idx_q    <= '0;
            rd_cnt_q    <= '0;
            wr_state_q  <= W_IDLE;
            wr_idx_q    <= '0;
            wr_rem_q    <= '0;
            stall_cnt_q <= '0;
            err_q       <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_idx_q    <= rd_idx_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_state_q  <= wr_state_d;
            wr_idx_q    <= wr_idx_d;
            wr_rem_q    <= wr_rem_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    avmm_sram_dp_core #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEM_WORDS    (MEM_WORDS),
        .READ_LATENCY (READ_LATENCY),
        .IDX_W        (IDX_W)
    ) u_core (
        .clk_i    (clk),
        .rst_i    (reset),
        .we_i     (ram_we),
        .waddr_i  (ram_waddr),
        .wdata_i  (ws_writedata),
        .re_i     (ram_re),
        .raddr_i  (ram_raddr),
        .rdata_o  (rs_readdata),
        .rvalid_o (rs_readdatavalid)
    );

endmodule

// File: tb/tb_avmm_burst_mem_slave.sv
// Scoreboard bench for avmm_burst_mem_slave: a transaction-level memory model
// predicts read beats, handshakes and error flags; a negedge monitor compares.
module tb_avmm_burst_mem_slave;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 512;
    localparam int RL = 2;
    localparam int MB = 256;
    localparam int SP = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] rs_address = '0;
    logic          rs_read = 1'b0;
    logic [8:0]    rs_burstcount = '0;
    logic          rs_waitrequest;
    logic [DW-1:0] rs_readdata;
    logic          rs_readdatavalid;
    logic [AW-1:0] ws_address = '0;
    logic          ws_write = 1'b0;
    logic [DW-1:0] ws_writedata = '0;
    logic [8:0]    ws_burstcount = '0;
    logic          ws_waitrequest;
    logic          err_clear = 1'b0;
    logic [2:0]    err_status;

    avmm_burst_mem_slave #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MEM_WORDS       (MW),
        .READ_LATENCY    (RL),
        .MAX_BURST       (MB),
        .WR_STALL_PERIOD (SP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rs_address       (rs_address),
        .rs_read          (rs_read),
        .rs_burstcount    (rs_burstcount),
        .rs_waitrequest   (rs_waitrequest),
        .rs_readdata      (rs_readdata),
        .rs_readdatavalid (rs_readdatavalid),
        .ws_address       (ws_address),
        .ws_write         (ws_write),
        .ws_writedata     (ws_writedata),
        .ws_burstcount    (ws_burstcount),
        .ws_waitrequest   (ws_waitrequest),
        .err_clear        (err_clear),
        .err_status       (err_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          edge_n;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          ecnt = 0;
    int          vld_cnt = 0;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] mmem [MW];
    logic [31:0] wbuf [256];
    int          m_rd_left = 0, m_rd_word = 0;
    int          m_wr_left = 0, m_wr_word = 0;
    int          m_phase = 0, bc = 0, w = 0;
    logic [2:0]  m_err = '0, new_err;
    logic        exp_wsw;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model + monitor: check what the DUT shows now, then advance the model
    // across the coming clock edge using the stimulus currently on the pins.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            m_rd_left = 0;
            m_wr_left = 0;
            m_err     = '0;
            m_phase   = 0;
        end else begin
            while (sb.size() > 0 && sb[0].edge_n < ecnt) begin
                checks++; errors++;
                $display("FAIL rd_beat_missing: no valid after edge %0d, expected data 0x%0h", sb[0].edge_n, sb[0].data);
                void'(sb.pop_front());
            end
            if (rs_readdatavalid) begin
                vld_cnt++;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected_valid: got data 0x%0h after edge %0d, expected no beat", rs_readdata, ecnt);
                end else begin
                    e = sb.pop_front();
                    chk("rd_beat_edge", ecnt, e.edge_n);
                    chk("rd_data", rs_readdata, e.data);
                end
            end else if (sb.size() > 0 && sb[0].edge_n == ecnt) begin
                checks++; errors++;
                $display("FAIL rd_beat_missing: valid=0 after edge %0d, expected data 0x%0h", ecnt, sb[0].data);
                void'(sb.pop_front());
            end

            exp_wsw = (m_wr_left > 0) && (m_phase == SP - 1);
            chk("rs_waitrequest", rs_waitrequest, m_rd_left > 0);
            chk("ws_waitrequest", ws_waitrequest, exp_wsw);
            chk("err_status", err_status, m_err);

            new_err = '0;
            if (m_rd_left > 0) begin
                sb.push_back('{mmem[m_rd_word], ecnt + RL});
                m_rd_word = (m_rd_word + 1) % MW;
                m_rd_left--;
            end else if (rs_read) begin
                bc = int'(rs_burstcount);
                if (bc < 1 || bc > MB) new_err[0] = 1'b1;
                else begin
                    m_rd_left = bc;
                    m_rd_word = int'((rs_address >> 2) % MW);
                end
                if (rs_address % 4 != 0) new_err[2] = 1'b1;
            end
            if (ws_write && !exp_wsw) begin
                if (m_wr_left == 0) begin
                    bc = int'(ws_burstcount);
                    if (bc < 1 || bc > MB) new_err[1] = 1'b1;
                    else begin
                        w = int'((ws_address >> 2) % MW);
                        mmem[w]   = ws_writedata;
                        m_wr_left = bc - 1;
                        m_wr_word = (w + 1) % MW;
                    end
                    if (ws_address % 4 != 0) new_err[2] = 1'b1;
                end else begin
                    mmem[m_wr_word] = ws_writedata;
                    m_wr_word = (m_wr_word + 1) % MW;
                    m_wr_left--;
                end
            end
            m_err   = (err_clear ? 3'b000 : m_err) | new_err;
            m_phase = (m_phase + 1) % SP;
        end
    end

    task automatic rd_cmd(input logic [31:0] addr, input logic [8:0] n_bc);
        int n = 0;
        while (rs_waitrequest && n < 600) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (rs_waitrequest) begin
            errors++;
            $display("FAIL rd_cmd_timeout: rs_waitrequest=1, expected 0 within 600 cycles");
        end
        rs_address = addr; rs_burstcount = n_bc; rs_read = 1'b1;
        @(posedge clk); #1;
        rs_read = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [8:0] n_bc, input int beats);
        int  n;
        bit  got;
        ws_address = addr; ws_burstcount = n_bc;
        for (int b = 0; b < beats; b++) begin
            ws_write = 1'b1; ws_writedata = wbuf[b];
            n = 0; got = 0;
            while (!got && n < 20) begin
                @(negedge clk);
                got = !ws_waitrequest;
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL wr_beat_timeout: beat %0d got waitrequest=1, expected accept within 20 cycles", b);
            end
        end
        ws_write = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || rs_waitrequest) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_rdvalid", rs_readdatavalid, 0);
        chk("rst_rdata", rs_readdata, 0);
        chk("rst_err", err_status, 0);
        chk("rst_rs_wait", rs_waitrequest, 0);
        chk("rst_ws_wait", ws_waitrequest, 0);

        // 4-beat write then readback
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        wr_burst(32'h100, 9'd4, 4);
        rd_cmd(32'h100, 9'd4);
        drain();

        // full 256-beat burst under stall injection, word k = k
        for (int i = 0; i < 256; i++) wbuf[i] = 32'(i);
        wr_burst(32'h0, 9'd256, 256);
        rd_cmd(32'h0, 9'd256);
        drain();

        // wrap past the top of memory
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        wr_burst(32'((MW - 4) * 4), 9'd4, 4);
        rd_cmd(32'((MW - 4) * 4), 9'd8);
        drain();

        // illegal burst counts
        rd_cmd(32'h40, 9'd0);
        wbuf[0] = 32'hDEAD_BEEF;
        wr_burst(32'h44, 9'd300, 1);
        @(posedge clk); #1;
        chk("err_illegal_bc", err_status, 3'b011);
        rd_cmd(32'h44, 9'd1);
        drain();
        pulse_clear();
        chk("err_cleared", err_status, 3'b000);

        // misaligned read uses truncated address
        rd_cmd(32'h102, 9'd2);
        drain();
        chk("err_align", err_status, 3'b100);
        pulse_clear();
        chk("err_align_cleared", err_status, 3'b000);

        // same-cycle read and write of word 7: read-first
        wbuf[0] = 32'h55;
        wr_burst(32'd28, 9'd1, 1);
        rs_address = 32'd28; rs_burstcount = 9'd1; rs_read = 1'b1;
        @(posedge clk); #1;
        rs_read = 1'b0;
        ws_address = 32'd28; ws_burstcount = 9'd1; ws_writedata = 32'hAA; ws_write = 1'b1;
        @(posedge clk); #1;
        ws_write = 1'b0;
        drain();
        rd_cmd(32'd28, 9'd1);
        drain();

        // randomized concurrent read and write traffic
        fork
            begin
                repeat (20) begin
                    rd_cmd(32'($urandom_range(0, 247) * 4), 9'($urandom_range(1, 8)));
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
            begin
                int nb;
                repeat (20) begin
                    nb = $urandom_range(1, 8);
                    for (int i = 0; i < nb; i++) wbuf[i] = $urandom;
                    wr_burst(32'($urandom_range(0, 247) * 4), 9'(nb), nb);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
        join
        drain();

        // reset in the middle of a 16-beat read
        vld_cnt = 0;
        rd_cmd(32'h0, 9'd16);
        begin
            int n = 0;
            while (vld_cnt < 5 && n < 50) begin @(posedge clk); #1; n++; end
            chk("mid_rd_valids_seen", vld_cnt >= 5, 1);
        end
        reset = 1'b1;
        #1;
        chk("rst_mid_rdvalid", rs_readdatavalid, 0);
        chk("rst_mid_rdata", rs_readdata, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_mid_rs_wait", rs_waitrequest, 0);
        chk("rst_mid_ws_wait", ws_waitrequest, 0);
        chk("rst_mid_err", err_status, 0);
        rd_cmd(32'h20, 9'd2);
        drain();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: %0d beats left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
